// File: rtl/mips_forward_bypass.sv
// EX-stage operand forwarding and interlock unit: a shadow pipeline of in-flight
// destinations feeds youngest-first operand bypass and load/ALU hazard stalls.
module mips_forward_bypass #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned LOAD_STAGE  = 1,
    parameter bit          DIRECT      = 1'b1,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [NPORTS*5-1:0]     issue_src,
    input  logic [NPORTS*WIDTH-1:0] issue_rf_data,
    input  logic [4:0]              issue_dest,
    input  logic                    issue_wen,
    input  logic                    issue_load,
    input  logic [WIDTH-1:0]        ex_result,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic                    hold,
    input  logic                    flush,
    output logic                    op_valid,
    output logic [NPORTS*WIDTH-1:0] op_data,
    output logic [NPORTS-1:0]       op_fwd,
    output logic [COUNT_WIDTH-1:0]  stall_count
);
    localparam int unsigned REG_W = 5;

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              load_q, load_d;
    logic [DEPTH-1:0]              ready_q, ready_d;
    logic [DEPTH-1:0][REG_W-1:0]   dest_q, dest_d;
    logic [DEPTH-1:0][WIDTH-1:0]   data_q, data_d;

    logic [NPORTS-1:0][REG_W-1:0]  src_c;
    logic [NPORTS-1:0][WIDTH-1:0]  rf_c;
    logic [NPORTS-1:0][WIDTH-1:0]  look_data_c;
    logic [NPORTS-1:0]             look_fwd_c;
    logic [NPORTS-1:0]             hazard_c;
    logic [NPORTS-1:0]             found_c;

    logic [NPORTS-1:0][WIDTH-1:0]  op_data_q, op_data_d;
    logic [NPORTS-1:0]             op_fwd_q, op_fwd_d;
    logic                          op_valid_q, op_valid_d;
    logic [COUNT_WIDTH-1:0]        stall_q, stall_d;
    logic                          issue_ready_c;
    logic                          fire_c;

    assign src_c = issue_src;
    assign rf_c  = issue_rf_data;

    // Youngest-first lookup; a match that cannot yet supply data hazards the port.
    always_comb begin
        look_data_c = rf_c;
        look_fwd_c  = '0;
        hazard_c    = '0;
        found_c     = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (src_c[p] != '0) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (!found_c[p] && valid_q[k] && (dest_q[k] == src_c[p])) begin
                        found_c[p] = 1'b1;
                        if (ready_q[k]) begin
                            look_data_c[p] = data_q[k];
                            look_fwd_c[p]  = 1'b1;
                        end else if (DIRECT && (k == 0) && !load_q[k]) begin
                            look_data_c[p] = ex_result;
                            look_fwd_c[p]  = 1'b1;
                        end else if (DIRECT && (k == LOAD_STAGE) && load_q[k]) begin
                            look_data_c[p] = mem_data;
                            look_fwd_c[p]  = 1'b1;
                        end else begin
                            hazard_c[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign issue_ready_c = !hold && (hazard_c == '0);
    assign fire_c        = issue_valid && issue_ready_c && !flush;

    // Shadow-pipeline shift, result capture, operand load and stall counting.
    always_comb begin
        valid_d    = valid_q;
        load_d     = load_q;
        ready_d    = ready_q;
        dest_d     = dest_q;
        data_d     = data_q;
        op_valid_d = op_valid_q;
        op_data_d  = op_data_q;
        op_fwd_d   = op_fwd_q;
        stall_d    = stall_q;

        if (!hold) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                ready_d[k] = ready_q[k-1];
                dest_d[k]  = dest_q[k-1];
                data_d[k]  = data_q[k-1];
                if ((k - 1 == 0) && !load_q[k-1]) begin
                    data_d[k]  = ex_result;
                    ready_d[k] = 1'b1;
                end
                if ((k - 1 == LOAD_STAGE) && load_q[k-1]) begin
                    data_d[k]  = mem_data;
                    ready_d[k] = 1'b1;
                end
            end
            // A flushed EX instruction must not survive into entry 1.
            valid_d[1] = valid_q[0] && !flush;

            valid_d[0] = fire_c && issue_wen;
            load_d[0]  = issue_load;
            ready_d[0] = 1'b0;
            dest_d[0]  = issue_dest;

            op_valid_d = fire_c;
            if (fire_c) begin
                op_data_d = look_data_c;
                op_fwd_d  = look_fwd_c;
            end

            if (issue_valid && !issue_ready_c && (stall_q != '1)) begin
                stall_d = stall_q + COUNT_WIDTH'(1);
            end
        end else if (flush) begin
            valid_d[0] = 1'b0;
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            load_q     <= '0;
            ready_q    <= '0;
            dest_q     <= '0;
            data_q     <= '0;
            op_valid_q <= 1'b0;
            op_data_q  <= '0;
            op_fwd_q   <= '0;
            stall_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            load_q     <= load_d;
            ready_q    <= ready_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            op_valid_q <= op_valid_d;
            op_data_q  <= op_data_d;
            op_fwd_q   <= op_fwd_d;
            stall_q    <= stall_d;
        end
    end

    assign issue_ready = issue_ready_c;
    assign op_valid    = op_valid_q;
    assign op_data     = op_data_q;
    assign op_fwd      = op_fwd_q;
    assign stall_count = stall_q;

endmodule
